// File: rtl/ibex_cc_pkg.sv
// Shared X-interface constants, request/response payload types and writeback FSM states.
package ibex_cc_pkg;

    localparam int unsigned XInterfaceNumRsp          = 2;
    localparam int unsigned XInterfaceMaxOutstanding  = 4;
    localparam bit          XInterfaceTernaryOps      = 1'b0;
    localparam bit          XInterfaceDualWriteback   = 1'b0;
    localparam int unsigned XifIdW                    = $clog2(XInterfaceMaxOutstanding);

    typedef struct packed {
        logic [31:0]      instr;
        logic [2:0][31:0] rs;
        logic [XifIdW-1:0] id;
    } xif_req_t;

    typedef struct packed {
        logic [XifIdW-1:0] id;
        logic              dual;
        logic [1:0][4:0]   rd;
        logic [1:0][31:0]  data;
    } xif_rsp_t;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_FIRST,
        WB_SECOND
    } wb_state_e;

endpackage

// File: rtl/ibex_xif_rr_arb.sv
// N-way round-robin arbiter: one-hot grant over valid, priority moves past the winner on ack.
module ibex_xif_rr_arb #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] valid,
    input  logic         ack,
    output logic [N-1:0] grant
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr;
    logic [PtrW-1:0] gidx;
    logic [PtrW-1:0] cand;

    // Walk from lowest to highest priority so the last hit (closest to ptr) wins.
    always_comb begin
        grant = '0;
        gidx  = ptr;
        cand  = ptr;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            cand = PtrW'((int'(ptr) + i) % int'(N));
            if (valid[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                gidx        = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (ack) begin
            ptr <= (int'(gidx) == int'(N) - 1) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/ibex_xif_offload_ctrl.sv
// Offload controller: tags core requests with IDs, bounds in-flight count, accepts
// out-of-order accelerator responses round-robin and serialises them onto one writeback port.
module ibex_xif_offload_ctrl
    import ibex_cc_pkg::*;
#(
    parameter int unsigned NumRsp         = XInterfaceNumRsp,
    parameter int unsigned MaxOutstanding = XInterfaceMaxOutstanding,
    parameter bit          TernaryOps     = XInterfaceTernaryOps,
    parameter bit          DualWriteback  = XInterfaceDualWriteback,
    localparam int unsigned IdW           = $clog2(MaxOutstanding)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           off_valid_i,
    output logic                           off_ready_o,
    input  logic [31:0]                    off_instr_i,
    input  logic [2:0][31:0]               off_rs_i,
    output logic                           q_valid_o,
    input  logic                           q_ready_i,
    output logic [31:0]                    q_instr_o,
    output logic [2:0][31:0]               q_rs_o,
    output logic [IdW-1:0]                 q_id_o,
    input  logic [NumRsp-1:0]              p_valid_i,
    output logic [NumRsp-1:0]              p_ready_o,
    input  logic [NumRsp-1:0][IdW-1:0]     p_id_i,
    input  logic [NumRsp-1:0]              p_dual_i,
    input  logic [NumRsp-1:0][1:0][4:0]    p_rd_i,
    input  logic [NumRsp-1:0][1:0][31:0]   p_data_i,
    output logic                           wb_valid_o,
    input  logic                           wb_ready_i,
    output logic [4:0]                     wb_rd_o,
    output logic [31:0]                    wb_data_o,
    output logic [IdW:0]                   outstanding_o,
    output logic                           err_o
);

    localparam logic [IdW:0] MaxCnt = MaxOutstanding[IdW:0];

    xif_req_t                  req_q;
    xif_rsp_t                  rsp_sel;
    wb_state_e                 wb_state;
    logic                      run_q;
    logic                      req_full;
    logic [MaxOutstanding-1:0] bitmap;
    logic [MaxOutstanding-1:0] bm_nxt;
    logic                      dual_q;
    logic [1:0][4:0]           rd_q;
    logic [1:0][31:0]          data_q;
    logic [NumRsp-1:0]         grant;
    logic                      q_hs;
    logic                      off_hs;
    logic                      acc;
    logic                      id_ok;
    logic                      rsp_retire;
    logic                      wb_sel;
    logic                      wb_step;
    logic                      wb_free;

    // The ID counter lives in the request register's id field.
    assign q_valid_o   = req_full && (outstanding_o != MaxCnt);
    assign q_hs        = q_valid_o && q_ready_i;
    assign off_ready_o = run_q && (!req_full || q_hs);
    assign off_hs      = off_valid_i && off_ready_o;
    assign q_instr_o   = req_q.instr;
    assign q_rs_o      = req_q.rs;
    assign q_id_o      = IdW'(req_q.id);

    assign wb_sel     = (wb_state == WB_SECOND);
    assign wb_rd_o    = rd_q[wb_sel];
    assign wb_data_o  = data_q[wb_sel];
    assign wb_valid_o = (wb_state != WB_IDLE) && (wb_rd_o != '0);
    assign wb_step    = (wb_state != WB_IDLE) && ((wb_rd_o == '0) || wb_ready_i);
    assign wb_free    = (wb_state == WB_IDLE) || (wb_step && (wb_sel || !dual_q));

    ibex_xif_rr_arb #(.N(NumRsp)) u_arb (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .valid (p_valid_i),
        .ack   (acc),
        .grant (grant)
    );

    assign p_ready_o = (run_q && wb_free) ? grant : '0;
    assign acc       = |p_ready_o;

    always_comb begin
        rsp_sel = '0;
        for (int i = 0; i < int'(NumRsp); i++) begin
            if (grant[i]) begin
                rsp_sel.id   = XifIdW'(p_id_i[i]);
                rsp_sel.dual = DualWriteback && p_dual_i[i];
                rsp_sel.rd   = p_rd_i[i];
                rsp_sel.data = p_data_i[i];
            end
        end
    end

    assign id_ok      = bitmap[rsp_sel.id];
    assign rsp_retire = acc && id_ok;

    // Clear after set: a same-ID retire only happens when the bit was already set.
    always_comb begin
        bm_nxt = bitmap;
        if (q_hs)       bm_nxt[req_q.id]   = 1'b1;
        if (rsp_retire) bm_nxt[rsp_sel.id] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q         <= 1'b0;
            req_full      <= 1'b0;
            req_q         <= '0;
            bitmap        <= '0;
            outstanding_o <= '0;
            err_o         <= 1'b0;
            wb_state      <= WB_IDLE;
            dual_q        <= 1'b0;
            rd_q          <= '0;
            data_q        <= '0;
        end else begin
            run_q <= 1'b1;
            if (off_hs) begin
                req_q.instr <= off_instr_i;
                req_q.rs[0] <= off_rs_i[0];
                req_q.rs[1] <= off_rs_i[1];
                req_q.rs[2] <= TernaryOps ? off_rs_i[2] : '0;
                req_full    <= 1'b1;
            end else if (q_hs) begin
                req_full <= 1'b0;
            end
            if (q_hs) req_q.id <= req_q.id + 1'b1;
            bitmap <= bm_nxt;
            case ({q_hs, rsp_retire})
                2'b10:   outstanding_o <= outstanding_o + 1'b1;
                2'b01:   outstanding_o <= outstanding_o - 1'b1;
                default: outstanding_o <= outstanding_o;
            endcase
            err_o <= acc && !id_ok;
            if (wb_step) wb_state <= (!wb_sel && dual_q) ? WB_SECOND : WB_IDLE;
            if (rsp_retire) begin
                wb_state <= WB_FIRST;
                dual_q   <= rsp_sel.dual;
                rd_q     <= rsp_sel.rd;
                data_q   <= rsp_sel.data;
            end
        end
    end

endmodule

// File: tb/tb_ibex_xif_offload_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_ibex_xif_offload_ctrl;

    localparam int NR = 2;
    localparam int IW = 2;

    logic                       clk_i = 1'b0;
    logic                       rst_ni;
    logic                       off_valid_i;
    logic                       off_ready_o;
    logic [31:0]                off_instr_i;
    logic [2:0][31:0]           off_rs_i;
    logic                       q_valid_o;
    logic                       q_ready_i;
    logic [31:0]                q_instr_o;
    logic [2:0][31:0]           q_rs_o;
    logic [IW-1:0]              q_id_o;
    logic [NR-1:0]              p_valid_i;
    logic [NR-1:0]              p_ready_o;
    logic [NR-1:0][IW-1:0]      p_id_i;
    logic [NR-1:0]              p_dual_i;
    logic [NR-1:0][1:0][4:0]    p_rd_i;
    logic [NR-1:0][1:0][31:0]   p_data_i;
    logic                       wb_valid_o;
    logic                       wb_ready_i;
    logic [4:0]                 wb_rd_o;
    logic [31:0]                wb_data_o;
    logic [IW:0]                outstanding_o;
    logic                       err_o;

    always #5 clk_i = ~clk_i;

    ibex_xif_offload_ctrl #(
        .NumRsp(NR), .MaxOutstanding(4), .TernaryOps(1'b0), .DualWriteback(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .off_valid_i(off_valid_i), .off_ready_o(off_ready_o),
        .off_instr_i(off_instr_i), .off_rs_i(off_rs_i),
        .q_valid_o(q_valid_o), .q_ready_i(q_ready_i), .q_instr_o(q_instr_o),
        .q_rs_o(q_rs_o), .q_id_o(q_id_o),
        .p_valid_i(p_valid_i), .p_ready_o(p_ready_o), .p_id_i(p_id_i),
        .p_dual_i(p_dual_i), .p_rd_i(p_rd_i), .p_data_i(p_data_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    typedef struct { logic [31:0] instr; logic [31:0] rs0, rs1, rs2; logic [IW-1:0] id; } qexp_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wbexp_t;
    typedef struct { logic [IW-1:0] id; logic dual; logic [4:0] rd0, rd1; logic [31:0] d0, d1; } rsp_t;

    qexp_t   exp_q[$];
    wbexp_t  exp_wb[$];
    rsp_t    chq[NR][$];
    int      grant_log[$];
    int      total = 0;
    int      bad = 0;
    int      err_seen = 0;
    logic [IW-1:0] next_id = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: writeback and request scoreboards, stall stability, err pulse counting.
    initial begin : monitor
        logic        stalled;
        logic [4:0]  st_rd;
        logic [31:0] st_data;
        wbexp_t      ew;
        qexp_t       eq;
        stalled = 1'b0;
        st_rd   = '0;
        st_data = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    check("wb_hold", {wb_valid_o, wb_rd_o, wb_data_o}, {1'b1, st_rd, st_data});
                stalled = wb_valid_o && !wb_ready_i;
                st_rd   = wb_rd_o;
                st_data = wb_data_o;
                if (wb_valid_o && wb_ready_i) begin
                    if (exp_wb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL wb_unexpected: got rd %0d data %0h, required no writeback", wb_rd_o, wb_data_o);
                    end else begin
                        ew = exp_wb.pop_front();
                        check("wb_rd", wb_rd_o, ew.rd);
                        check("wb_data", wb_data_o, ew.data);
                    end
                end
                if (q_valid_o && q_ready_i) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL q_unexpected: got id %0d, required no request", q_id_o);
                    end else begin
                        eq = exp_q.pop_front();
                        check("q_id", q_id_o, eq.id);
                        check("q_payload", {q_instr_o, q_rs_o[0], q_rs_o[1], q_rs_o[2]},
                              {eq.instr, eq.rs0, eq.rs1, eq.rs2});
                    end
                end
                if (err_o) err_seen++;
            end
        end
    end

    // Response driver: presents the head of each channel queue until accepted.
    initial begin : driver
        logic [NR-1:0] acc;
        int            wait_cnt[NR];
        p_valid_i = '0; p_id_i = '0; p_dual_i = '0; p_rd_i = '0; p_data_i = '0;
        for (int c = 0; c < NR; c++) wait_cnt[c] = 0;
        forever begin
            @(negedge clk_i);
            acc = p_ready_o & p_valid_i;
            @(posedge clk_i);
            #1;
            for (int c = 0; c < NR; c++) begin
                if (acc[c] && chq[c].size() > 0) begin
                    void'(chq[c].pop_front());
                    grant_log.push_back(c);
                    wait_cnt[c] = 0;
                end else if (chq[c].size() > 0) begin
                    wait_cnt[c]++;
                    if (wait_cnt[c] > 200) begin
                        total++;
                        bad++;
                        $display("FAIL rsp_timeout ch%0d: not accepted within 200 cycles", c);
                        void'(chq[c].pop_front());
                        wait_cnt[c] = 0;
                    end
                end
                if (chq[c].size() > 0) begin
                    p_valid_i[c]   = 1'b1;
                    p_id_i[c]      = chq[c][0].id;
                    p_dual_i[c]    = chq[c][0].dual;
                    p_rd_i[c][0]   = chq[c][0].rd0;
                    p_rd_i[c][1]   = chq[c][0].rd1;
                    p_data_i[c][0] = chq[c][0].d0;
                    p_data_i[c][1] = chq[c][0].d1;
                end else begin
                    p_valid_i[c] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        exp_q.delete();
        exp_wb.delete();
        for (int c = 0; c < NR; c++) chq[c].delete();
        grant_log.delete();
        off_valid_i = 1'b0;
        wb_ready_i  = 1'b1;
        q_ready_i   = 1'b1;
        next_id     = '0;
        settle(2);
        err_seen = 0;
        rst_ni   = 1'b1;
        tick();
    endtask

    task automatic offload(input logic [31:0] instr, input logic [31:0] r0, input logic [31:0] r1,
                           input logic [31:0] r2);
        int n;
        off_valid_i = 1'b1;
        off_instr_i = instr;
        off_rs_i[0] = r0;
        off_rs_i[1] = r1;
        off_rs_i[2] = r2;
        exp_q.push_back('{instr: instr, rs0: r0, rs1: r1, rs2: 32'h0, id: next_id});
        next_id++;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!off_ready_o && n < 100);
        if (!off_ready_o) begin
            total++;
            bad++;
            $display("FAIL offload_timeout: off_ready_o low for %0d cycles", n);
        end
        tick();
        off_valid_i = 1'b0;
    endtask

    task automatic push_rsp(input int ch, input logic [IW-1:0] id, input logic dual,
                            input logic [4:0] rd0, input logic [31:0] d0,
                            input logic [4:0] rd1, input logic [31:0] d1);
        chq[ch].push_back('{id: id, dual: dual, rd0: rd0, rd1: rd1, d0: d0, d1: d1});
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
        exp_wb.push_back('{rd: rd, data: data});
    endtask

    task automatic wait_wb_valid();
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!wb_valid_o && n < 50);
        check("wb_valid_seen", wb_valid_o, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {off_ready_o, p_ready_o}, '0);
        check({tag, "_valid"}, {q_valid_o, wb_valid_o, err_o}, '0);
        check({tag, "_data"}, {q_instr_o, q_id_o, wb_rd_o, wb_data_o, outstanding_o}, '0);
    endtask

    initial begin
        rst_ni = 1'b0;
        off_valid_i = 1'b0; off_instr_i = '0; off_rs_i = '0;
        q_ready_i = 1'b1; wb_ready_i = 1'b1;
        @(negedge clk_i);
        check_idle_outputs("reset");
        apply_reset();

        // Single offload and response.
        offload(32'h1234_5678, 32'h1, 32'h2, 32'h3);
        settle(3);
        check("t1_out_before", outstanding_o, 1);
        push_wb(5'd5, 32'hA5A5_0001);
        push_rsp(0, 2'd0, 1'b0, 5'd5, 32'hA5A5_0001, 5'd0, 32'h0);
        settle(5);
        check("t1_out_after", outstanding_o, 0);
        check("t1_wb_drained", exp_wb.size(), 0);

        // Outstanding limit: fifth request is held until a response retires.
        apply_reset();
        for (int i = 0; i < 5; i++)
            offload(32'h0000_1000 + i, 32'h10 + i, 32'h20 + i, 32'h30 + i);
        settle(3);
        check("t2_q_valid_held", q_valid_o, 1'b0);
        check("t2_out_full", outstanding_o, 4);
        check("t2_off_ready_low", off_ready_o, 1'b0);
        check("t2_q_pending", exp_q.size(), 1);
        push_wb(5'd9, 32'h99);
        push_rsp(1, 2'd2, 1'b0, 5'd9, 32'h99, 5'd0, 32'h0);
        settle(5);
        check("t2_q_drained", exp_q.size(), 0);
        check("t2_out_refilled", outstanding_o, 4);

        // Round-robin: ch0 wins first, ch1 wins the next contest.
        apply_reset();
        for (int i = 0; i < 3; i++) offload(32'hC0DE_0000 + i, 32'h0, 32'h0, 32'h0);
        settle(3);
        push_wb(5'd10, 32'h10);
        push_wb(5'd11, 32'h11);
        push_wb(5'd12, 32'h12);
        push_rsp(0, 2'd1, 1'b0, 5'd10, 32'h10, 5'd0, 32'h0);
        push_rsp(0, 2'd2, 1'b0, 5'd12, 32'h12, 5'd0, 32'h0);
        push_rsp(1, 2'd0, 1'b0, 5'd11, 32'h11, 5'd0, 32'h0);
        settle(8);
        check("t3_grant_cnt", grant_log.size(), 3);
        if (grant_log.size() == 3)
            check("t3_grant_order", {grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0]}, 12'h010);
        check("t3_wb_drained", exp_wb.size(), 0);
        check("t3_out", outstanding_o, 0);

        // Dual writeback with a stalled register file.
        apply_reset();
        offload(32'hD0A1_0000, 32'h0, 32'h0, 32'h0);
        offload(32'hD0A1_0001, 32'h0, 32'h0, 32'h0);
        settle(3);
        wb_ready_i = 1'b0;
        push_wb(5'd3, 32'h11);
        push_wb(5'd7, 32'h22);
        push_wb(5'd4, 32'h44);
        push_rsp(0, 2'd0, 1'b1, 5'd3, 32'h11, 5'd7, 32'h22);
        push_rsp(1, 2'd1, 1'b0, 5'd4, 32'h44, 5'd0, 32'h0);
        wait_wb_valid();
        check("t4_first_rd", wb_rd_o, 5'd3);
        check("t4_p_ready_stall1", p_ready_o, 2'b00);
        tick();
        @(negedge clk_i);
        check("t4_p_ready_stall2", p_ready_o, 2'b00);
        tick();
        wb_ready_i = 1'b1;
        @(negedge clk_i);
        check("t4_p_ready_first_done", p_ready_o, 2'b00);
        tick();
        @(negedge clk_i);
        check("t4_second_rd", wb_rd_o, 5'd7);
        check("t4_p_ready_second_done", p_ready_o, 2'b10);
        settle(5);
        check("t4_wb_drained", exp_wb.size(), 0);
        check("t4_out", outstanding_o, 0);

        // Unissued ID and rd0 == 0: no writebacks, one error pulse.
        apply_reset();
        offload(32'hE000_0000, 32'h0, 32'h0, 32'h0);
        settle(3);
        push_rsp(1, 2'd2, 1'b0, 5'd6, 32'h66, 5'd0, 32'h0);
        settle(5);
        check("t5_err_once", err_seen, 1);
        check("t5_out_unchanged", outstanding_o, 1);
        push_rsp(0, 2'd0, 1'b0, 5'd0, 32'h55, 5'd0, 32'h0);
        settle(5);
        check("t5_out_retired", outstanding_o, 0);
        check("t5_err_still_once", err_seen, 1);
        check("t5_rsp_consumed", grant_log.size(), 2);

        // Reset with work in flight and writeback stalled.
        apply_reset();
        offload(32'hF000_0000, 32'h0, 32'h0, 32'h0);
        offload(32'hF000_0001, 32'h0, 32'h0, 32'h0);
        settle(3);
        wb_ready_i = 1'b0;
        push_wb(5'd8, 32'h88);
        push_rsp(0, 2'd0, 1'b0, 5'd8, 32'h88, 5'd0, 32'h0);
        wait_wb_valid();
        tick();
        rst_ni = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("t6_reset");
        apply_reset();
        offload(32'hF000_0002, 32'h7, 32'h8, 32'h9);
        settle(3);
        check("t6_q_drained", exp_q.size(), 0);
        check("t6_out", outstanding_o, 1);
        check("t6_no_err", err_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
